// File: rtl/race_sequencer.sv
// ---------------------------------------------------------------------------
// race_sequencer
// Game-flow controller for the player car. It sequences a race through
// countdown, racing, level pause and end-of-game states. It also keeps lives,
// fuel and per-level distance. All game decisions are taken on frame ticks,
// except the game start, the fuel pickup and the edge hit, which act on any
// cycle. Every output is a register.
//
// Ports
//   clk, reset       : system clock, synchronous active-high reset
//   startOfFrame     : one-cycle frame tick
//   start_key        : level signal, rising edge starts a game
//   car_speed [7:0]  : distance units added per frame tick while racing
//   hit_edge         : road-edge collision, rising edge costs a life
//   fuel_pickup      : one-cycle pulse, adds FUEL_BONUS while racing
//   level [2:0]      : current level
//   gameOver         : high in GAME_OVER and WIN
//   race_active      : high in RACE
//   countdown [1:0]  : 3/2/1 during the countdown, else 0
//   fuel [9:0]       : remaining fuel
//   lives [1:0]      : remaining lives
//   distance [15:0]  : distance covered in the current level
//   level_done       : one-cycle pulse on entry to LEVEL_DONE
//   win              : high in WIN
// ---------------------------------------------------------------------------
module race_sequencer #(
    parameter int FRAMES_PER_DIGIT   = 30,
    parameter int LEVEL_DISTANCE     = 20000,
    parameter int FUEL_MAX           = 900,
    parameter int FUEL_BONUS         = 200,
    parameter int LIVES              = 3,
    parameter int INVULN_FRAMES      = 30,
    parameter int LEVEL_PAUSE_FRAMES = 60,
    parameter int NUM_LEVELS         = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        start_key,
    input  logic [7:0]  car_speed,
    input  logic        hit_edge,
    input  logic        fuel_pickup,
    output logic [2:0]  level,
    output logic        gameOver,
    output logic        race_active,
    output logic [1:0]  countdown,
    output logic [9:0]  fuel,
    output logic [1:0]  lives,
    output logic [15:0] distance,
    output logic        level_done,
    output logic        win
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_COUNTDOWN  = 3'd1,
        S_RACE       = 3'd2,
        S_LEVEL_DONE = 3'd3,
        S_GAME_OVER  = 3'd4,
        S_WIN        = 3'd5
    } state_t;

    localparam logic [15:0] LP_DIGIT_LAST = 16'(FRAMES_PER_DIGIT - 1);
    localparam logic [15:0] LP_PAUSE_LAST = 16'(LEVEL_PAUSE_FRAMES - 1);
    localparam logic [15:0] LP_INVULN     = 16'(INVULN_FRAMES);
    localparam logic [9:0]  LP_FUEL_MAX   = 10'(FUEL_MAX);
    localparam logic [11:0] LP_FUEL_MAX_W = 12'(FUEL_MAX);
    localparam logic [11:0] LP_BONUS_W    = 12'(FUEL_BONUS);
    localparam logic [1:0]  LP_LIVES      = 2'(LIVES);
    localparam logic [2:0]  LP_LAST_LEVEL = 3'(NUM_LEVELS - 1);
    localparam logic [16:0] LP_LEVEL_DIST = 17'(LEVEL_DISTANCE);

    state_t      r_state;
    logic        r_start_d;
    logic        r_hit_d;
    logic        r_mask;      // high for the first cycle after reset: no edges then
    logic [1:0]  r_digit;
    logic [15:0] r_sub;
    logic [15:0] r_invuln;
    logic [15:0] r_pause;

    state_t      w_state;
    logic [2:0]  w_level;
    logic [9:0]  w_fuel;
    logic [1:0]  w_lives;
    logic [15:0] w_distance;
    logic [1:0]  w_digit;
    logic [15:0] w_sub;
    logic [15:0] w_invuln;
    logic [15:0] w_pause;
    logic        w_level_done;

    logic        w_start_rise;
    logic        w_hit_rise;
    logic        w_hit_take;
    logic [16:0] w_dist_sum;
    logic [15:0] w_dist_sat;
    logic [11:0] w_fuel_add;
    logic [9:0]  w_fuel_pre;
    logic [9:0]  w_fuel_tick;

    // A level held high across reset release is masked for one cycle,
    // so it never looks like a rise.
    assign w_start_rise = start_key & ~r_start_d & ~r_mask;
    assign w_hit_rise   = hit_edge  & ~r_hit_d   & ~r_mask;
    assign w_hit_take   = w_hit_rise && (r_invuln == 16'd0) && (lives != 2'd0);

    assign w_dist_sum  = {1'b0, distance} + {9'd0, car_speed};
    assign w_dist_sat  = w_dist_sum[16] ? 16'hFFFF : w_dist_sum[15:0];

    // Pickup is applied before the frame decrement, so a coincident
    // pickup and tick give min(fuel + bonus, max) - 1.
    assign w_fuel_add  = {2'b00, fuel} + LP_BONUS_W;
    assign w_fuel_pre  = !fuel_pickup ? fuel :
                         (w_fuel_add > LP_FUEL_MAX_W) ? LP_FUEL_MAX : w_fuel_add[9:0];
    assign w_fuel_tick = (w_fuel_pre == 10'd0) ? 10'd0 : (w_fuel_pre - 10'd1);

    // Next-state and next-value logic for the game flow.
    always_comb begin
        w_state      = r_state;
        w_level      = level;
        w_fuel       = fuel;
        w_lives      = lives;
        w_distance   = distance;
        w_digit      = r_digit;
        w_sub        = r_sub;
        w_invuln     = r_invuln;
        w_pause      = r_pause;
        w_level_done = 1'b0;
        case (r_state)
            S_IDLE, S_GAME_OVER, S_WIN: begin
                if (w_start_rise) begin
                    w_state    = S_COUNTDOWN;
                    w_level    = 3'd0;
                    w_lives    = LP_LIVES;
                    w_fuel     = LP_FUEL_MAX;
                    w_distance = 16'd0;
                    w_digit    = 2'd3;
                    w_sub      = 16'd0;
                    w_invuln   = 16'd0;
                    w_pause    = 16'd0;
                end else begin
                    w_state = r_state;
                end
            end
            S_COUNTDOWN: begin
                if (startOfFrame) begin
                    if (r_sub == LP_DIGIT_LAST) begin
                        w_sub = 16'd0;
                        if (r_digit == 2'd1) begin
                            w_state = S_RACE;
                            w_digit = 2'd0;
                        end else begin
                            w_digit = r_digit - 2'd1;
                        end
                    end else begin
                        w_sub = r_sub + 16'd1;
                    end
                end else begin
                    w_sub = r_sub;
                end
            end
            S_RACE: begin
                if (startOfFrame) begin
                    w_fuel     = w_fuel_tick;
                    w_distance = w_dist_sat;
                end else begin
                    w_fuel     = w_fuel_pre;
                end
                if (w_hit_take) begin
                    w_lives  = lives - 2'd1;
                    w_invuln = LP_INVULN;
                end else if (startOfFrame && (r_invuln != 16'd0)) begin
                    w_invuln = r_invuln - 16'd1;
                end else begin
                    w_invuln = r_invuln;
                end
                // Losing the last life beats finishing the level, which beats
                // running dry on the same tick.
                if (w_hit_take && (lives == 2'd1)) begin
                    w_state = S_GAME_OVER;
                end else if (startOfFrame && ({1'b0, w_dist_sat} >= LP_LEVEL_DIST)) begin
                    w_state      = S_LEVEL_DONE;
                    w_level_done = 1'b1;
                    w_distance   = 16'd0;
                    w_invuln     = 16'd0;
                    w_pause      = 16'd0;
                end else if (startOfFrame && (w_fuel_tick == 10'd0)) begin
                    w_state = S_GAME_OVER;
                end else begin
                    w_state = S_RACE;
                end
            end
            S_LEVEL_DONE: begin
                if (startOfFrame) begin
                    if (r_pause == LP_PAUSE_LAST) begin
                        w_pause = 16'd0;
                        if (level == LP_LAST_LEVEL) begin
                            w_state = S_WIN;
                        end else begin
                            w_state = S_COUNTDOWN;
                            w_level = level + 3'd1;
                            w_fuel  = LP_FUEL_MAX;
                            w_digit = 2'd3;
                            w_sub   = 16'd0;
                        end
                    end else begin
                        w_pause = r_pause + 16'd1;
                    end
                end else begin
                    w_pause = r_pause;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_start_d   <= 1'b0;
            r_hit_d     <= 1'b0;
            r_mask      <= 1'b1;
            r_digit     <= 2'd0;
            r_sub       <= 16'd0;
            r_invuln    <= 16'd0;
            r_pause     <= 16'd0;
            level       <= 3'd0;
            gameOver    <= 1'b0;
            race_active <= 1'b0;
            countdown   <= 2'd0;
            fuel        <= LP_FUEL_MAX;
            lives       <= LP_LIVES;
            distance    <= 16'd0;
            level_done  <= 1'b0;
            win         <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_start_d   <= start_key;
            r_hit_d     <= hit_edge;
            r_mask      <= 1'b0;
            r_digit     <= w_digit;
            r_sub       <= w_sub;
            r_invuln    <= w_invuln;
            r_pause     <= w_pause;
            level       <= w_level;
            gameOver    <= (w_state == S_GAME_OVER) || (w_state == S_WIN);
            race_active <= (w_state == S_RACE);
            countdown   <= (w_state == S_COUNTDOWN) ? w_digit : 2'd0;
            fuel        <= w_fuel;
            lives       <= w_lives;
            distance    <= w_distance;
            level_done  <= w_level_done;
            win         <= (w_state == S_WIN);
        end
    end

endmodule

// File: tb/tb_race_sequencer.sv
// ---------------------------------------------------------------------------
// tb_race_sequencer
// Directed self-checking bench for race_sequencer with default parameters.
// Inputs are driven on the falling edge and outputs sampled on the falling
// edge. A frame tick is a one-cycle startOfFrame pulse followed by one idle
// cycle.
// ---------------------------------------------------------------------------
module tb_race_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        startOfFrame = 1'b0;
    logic        start_key = 1'b0;
    logic [7:0]  car_speed = 8'd0;
    logic        hit_edge = 1'b0;
    logic        fuel_pickup = 1'b0;
    logic [2:0]  level;
    logic        gameOver;
    logic        race_active;
    logic [1:0]  countdown;
    logic [9:0]  fuel;
    logic [1:0]  lives;
    logic [15:0] distance;
    logic        level_done;
    logic        win;

    int checks = 0;
    int errors = 0;

    race_sequencer dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .start_key(start_key), .car_speed(car_speed), .hit_edge(hit_edge),
        .fuel_pickup(fuel_pickup), .level(level), .gameOver(gameOver),
        .race_active(race_active), .countdown(countdown), .fuel(fuel),
        .lives(lives), .distance(distance), .level_done(level_done), .win(win)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); startOfFrame = 1'b1;
            @(negedge clk); startOfFrame = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start_key = 1'b1;
        @(negedge clk); start_key = 1'b0;
    endtask

    task automatic pulse_hit();
        @(negedge clk); hit_edge = 1'b1;
        @(negedge clk); hit_edge = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d expected 0", level); end
        checks++; if (gameOver !== 1'b0) begin errors++; $display("FAIL rst_gameOver: got %0d expected 0", gameOver); end
        checks++; if (race_active !== 1'b0) begin errors++; $display("FAIL rst_race_active: got %0d expected 0", race_active); end
        checks++; if (countdown !== 2'd0) begin errors++; $display("FAIL rst_countdown: got %0d expected 0", countdown); end
        checks++; if (fuel !== 10'd900) begin errors++; $display("FAIL rst_fuel: got %0d expected 900", fuel); end
        checks++; if (lives !== 2'd3) begin errors++; $display("FAIL rst_lives: got %0d expected 3", lives); end
        checks++; if (distance !== 16'd0) begin errors++; $display("FAIL rst_distance: got %0d expected 0", distance); end
        checks++; if (level_done !== 1'b0) begin errors++; $display("FAIL rst_level_done: got %0d expected 0", level_done); end
        checks++; if (win !== 1'b0) begin errors++; $display("FAIL rst_win: got %0d expected 0", win); end
    endtask

    task automatic test_countdown();
        do_reset();
        pulse_start();
        checks++; if (countdown !== 2'd3) begin errors++; $display("FAIL cd_start: got %0d expected 3", countdown); end
        checks++; if (lives !== 2'd3 || fuel !== 10'd900 || level !== 3'd0) begin errors++; $display("FAIL cd_load: got lives=%0d fuel=%0d level=%0d expected 3 900 0", lives, fuel, level); end
        tick(29);
        checks++; if (countdown !== 2'd3) begin errors++; $display("FAIL cd_3_t29: got %0d expected 3", countdown); end
        tick(1);
        checks++; if (countdown !== 2'd2) begin errors++; $display("FAIL cd_2_t30: got %0d expected 2", countdown); end
        tick(29);
        checks++; if (countdown !== 2'd2) begin errors++; $display("FAIL cd_2_t59: got %0d expected 2", countdown); end
        tick(1);
        checks++; if (countdown !== 2'd1) begin errors++; $display("FAIL cd_1_t60: got %0d expected 1", countdown); end
        tick(29);
        checks++; if (countdown !== 2'd1 || race_active !== 1'b0) begin errors++; $display("FAIL cd_1_t89: got cd=%0d ra=%0d expected 1 0", countdown, race_active); end
        tick(1);
        checks++; if (countdown !== 2'd0 || race_active !== 1'b1) begin errors++; $display("FAIL cd_race_t90: got cd=%0d ra=%0d expected 0 1", countdown, race_active); end
        // start_key rise while racing is ignored
        pulse_start();
        checks++; if (race_active !== 1'b1 || countdown !== 2'd0) begin errors++; $display("FAIL start_in_race: got ra=%0d cd=%0d expected 1 0", race_active, countdown); end
    endtask

    task automatic test_level_progression();
        do_reset();
        pulse_start();
        tick(90);
        car_speed = 8'd200;
        tick(99);
        checks++; if (distance !== 16'd19800 || fuel !== 10'd801) begin errors++; $display("FAIL lvl_t99: got dist=%0d fuel=%0d expected 19800 801", distance, fuel); end
        tick(1);
        checks++; if (level_done !== 1'b1 || distance !== 16'd0 || race_active !== 1'b0) begin errors++; $display("FAIL lvl_done: got ld=%0d dist=%0d ra=%0d expected 1 0 0", level_done, distance, race_active); end
        @(negedge clk);
        checks++; if (level_done !== 1'b0) begin errors++; $display("FAIL lvl_done_pulse: got %0d expected 0", level_done); end
        tick(59);
        checks++; if (level !== 3'd0 || countdown !== 2'd0) begin errors++; $display("FAIL lvl_pause59: got level=%0d cd=%0d expected 0 0", level, countdown); end
        tick(1);
        checks++; if (level !== 3'd1 || fuel !== 10'd900 || countdown !== 2'd3 || lives !== 2'd3) begin errors++; $display("FAIL lvl_next: got level=%0d fuel=%0d cd=%0d lives=%0d expected 1 900 3 3", level, fuel, countdown, lives); end
        car_speed = 8'd0;
    endtask

    task automatic test_lives();
        do_reset();
        pulse_start();
        tick(90);
        car_speed = 8'd0;
        pulse_hit();
        checks++; if (lives !== 2'd2) begin errors++; $display("FAIL hit1: got %0d expected 2", lives); end
        tick(10);
        pulse_hit();
        checks++; if (lives !== 2'd2) begin errors++; $display("FAIL hit_invuln: got %0d expected 2", lives); end
        tick(31);
        pulse_hit();
        checks++; if (lives !== 2'd1 || race_active !== 1'b1) begin errors++; $display("FAIL hit2: got lives=%0d ra=%0d expected 1 1", lives, race_active); end
        tick(31);
        pulse_hit();
        checks++; if (lives !== 2'd0 || gameOver !== 1'b1 || race_active !== 1'b0 || win !== 1'b0) begin errors++; $display("FAIL hit3_over: got lives=%0d go=%0d ra=%0d win=%0d expected 0 1 0 0", lives, gameOver, race_active, win); end
        tick(3);
        checks++; if (gameOver !== 1'b1 || lives !== 2'd0) begin errors++; $display("FAIL over_hold: got go=%0d lives=%0d expected 1 0", gameOver, lives); end
        pulse_start();
        checks++; if (gameOver !== 1'b0 || countdown !== 2'd3 || lives !== 2'd3) begin errors++; $display("FAIL restart: got go=%0d cd=%0d lives=%0d expected 0 3 3", gameOver, countdown, lives); end
    endtask

    task automatic test_fuel();
        do_reset();
        pulse_start();
        tick(90);
        car_speed = 8'd0;
        tick(100);
        checks++; if (fuel !== 10'd800) begin errors++; $display("FAIL fuel_t100: got %0d expected 800", fuel); end
        @(negedge clk); fuel_pickup = 1'b1;
        @(negedge clk); fuel_pickup = 1'b0;
        checks++; if (fuel !== 10'd900) begin errors++; $display("FAIL pickup_cap: got %0d expected 900", fuel); end
        tick(400);
        checks++; if (fuel !== 10'd500) begin errors++; $display("FAIL fuel_500: got %0d expected 500", fuel); end
        @(negedge clk); fuel_pickup = 1'b1; startOfFrame = 1'b1;
        @(negedge clk); fuel_pickup = 1'b0; startOfFrame = 1'b0;
        checks++; if (fuel !== 10'd699) begin errors++; $display("FAIL pickup_tick: got %0d expected 699", fuel); end
        // exhaustion from a fresh game
        do_reset();
        pulse_start();
        tick(90);
        tick(899);
        checks++; if (fuel !== 10'd1 || race_active !== 1'b1) begin errors++; $display("FAIL fuel_t899: got fuel=%0d ra=%0d expected 1 1", fuel, race_active); end
        tick(1);
        checks++; if (fuel !== 10'd0 || gameOver !== 1'b1 || race_active !== 1'b0) begin errors++; $display("FAIL fuel_empty: got fuel=%0d go=%0d ra=%0d expected 0 1 0", fuel, gameOver, race_active); end
    endtask

    task automatic test_priority();
        do_reset();
        pulse_start();
        tick(90);
        car_speed = 8'd200;
        pulse_hit();
        tick(31);
        pulse_hit();
        tick(68);
        checks++; if (lives !== 2'd1 || distance !== 16'd19800) begin errors++; $display("FAIL prio_setup: got lives=%0d dist=%0d expected 1 19800", lives, distance); end
        @(negedge clk); hit_edge = 1'b1; startOfFrame = 1'b1;
        @(negedge clk); hit_edge = 1'b0; startOfFrame = 1'b0;
        checks++; if (gameOver !== 1'b1 || level_done !== 1'b0 || lives !== 2'd0 || win !== 1'b0) begin errors++; $display("FAIL prio_over: got go=%0d ld=%0d lives=%0d win=%0d expected 1 0 0 0", gameOver, level_done, lives, win); end
        car_speed = 8'd0;
    endtask

    task automatic test_win();
        do_reset();
        pulse_start();
        car_speed = 8'd200;
        for (int lv = 0; lv < 8; lv++) begin
            tick(90);
            checks++; if (race_active !== 1'b1 || level !== 3'(lv)) begin errors++; $display("FAIL win_race_l%0d: got ra=%0d level=%0d expected 1 %0d", lv, race_active, level, lv); end
            tick(100);
            checks++; if (level_done !== 1'b1) begin errors++; $display("FAIL win_done_l%0d: got %0d expected 1", lv, level_done); end
            tick(60);
        end
        checks++; if (win !== 1'b1 || gameOver !== 1'b1 || level !== 3'd7 || race_active !== 1'b0) begin errors++; $display("FAIL win_final: got win=%0d go=%0d level=%0d ra=%0d expected 1 1 7 0", win, gameOver, level, race_active); end
        car_speed = 8'd0;
    endtask

    task automatic test_reset_mid_race();
        do_reset();
        pulse_start();
        tick(90);
        car_speed = 8'd200;
        tick(10);
        @(negedge clk); reset = 1'b1; start_key = 1'b1;
        @(negedge clk);
        checks++; if (race_active !== 1'b0 || distance !== 16'd0 || fuel !== 10'd900 || lives !== 2'd3 || countdown !== 2'd0 || gameOver !== 1'b0) begin errors++; $display("FAIL mid_reset: got ra=%0d dist=%0d fuel=%0d lives=%0d cd=%0d go=%0d expected 0 0 900 3 0 0", race_active, distance, fuel, lives, countdown, gameOver); end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (countdown !== 2'd0 || race_active !== 1'b0) begin errors++; $display("FAIL held_start: got cd=%0d ra=%0d expected 0 0", countdown, race_active); end
        start_key = 1'b0;
        car_speed = 8'd0;
        pulse_start();
        checks++; if (countdown !== 2'd3) begin errors++; $display("FAIL start_after_reset: got %0d expected 3", countdown); end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_level_progression();
        test_lives();
        test_fuel();
        test_priority();
        test_win();
        test_reset_mid_race();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
